// File: rtl/uart_rx_fifo_if.sv
// Bundle of the UART receive FIFO's byte-capture, host-read and status signals.
// The master side is the UART receiver/host. The slave side is the FIFO.
interface uart_rx_fifo_if #(
    parameter int ADDR_W = 4
);
    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic              rd_en;
    logic              clr_ovf;
    logic [7:0]        rd_data;
    logic              rd_valid;
    logic [ADDR_W:0]   level;
    logic              full;
    logic              empty;
    logic              rts;
    logic              overflow;

    modport master (
        output rx_valid, rx_byte, rd_en, clr_ovf,
        input  rd_data, rd_valid, level, full, empty, rts, overflow
    );

    modport slave (
        input  rx_valid, rx_byte, rd_en, clr_ovf,
        output rd_data, rd_valid, level, full, empty, rts, overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO for a UART, with first-word-fall-through reads.
// The rts flow-control line has hysteresis between AFULL_LEVEL and RESUME_LEVEL.
// A sticky overflow flag records any byte dropped while the FIFO was full.
module uart_rx_fifo #(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int AFULL_LEVEL  = 12,
    parameter int RESUME_LEVEL = 4
) (
    input  logic           clk,
    input  logic           reset,
    uart_rx_fifo_if.slave  bus
);
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_L  = (ADDR_W+1)'(AFULL_LEVEL);
    localparam logic [ADDR_W:0] RESUME_L = (ADDR_W+1)'(RESUME_LEVEL);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} rts_state_t;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              ovf_q, ovf_d;
    rts_state_t        state_q;
    logic              rts_q;

    logic full_w, empty_w;
    logic push, pop, drop;

    // Status flags come from the registered level only.
    // This keeps input glitches off these outputs.
    assign full_w  = (level_q == DEPTH_L);
    assign empty_w = (level_q == '0);

    // Decide the push, pop and drop actions, then compute the next pointers, level and overflow.
    always_comb begin
        pop      = bus.rd_en & ~empty_w;
        push     = bus.rx_valid & (~full_w | pop);
        drop     = bus.rx_valid & full_w & ~pop;

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end

        // A new drop takes priority over a clear requested in the same cycle.
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // Register the pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Store the byte storage. The contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.rx_byte;
        end
    end

    // rts hysteresis FSM. It looks at the next level, so rts moves together with level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            rts_q   <= 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (level_d >= AFULL_L) begin
                        state_q <= HOLD;
                        rts_q   <= 1'b0;
                    end
                end
                HOLD: begin
                    if (level_d <= RESUME_L) begin
                        state_q <= RUN;
                        rts_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= RUN;
                    rts_q   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.rd_data  = mem[rd_ptr_q];
    assign bus.rd_valid = ~empty_w;
    assign bus.level    = level_q;
    assign bus.full     = full_w;
    assign bus.empty    = empty_w;
    assign bus.rts      = rts_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo.
// The bench has three parts:
//   - a directed vector table for the basic push/pop case;
//   - hand sequences for the threshold, overflow, wrap, empty-bypass and reset cases;
//   - randomized traffic checked against a queue-based reference model.
module tb_uart_rx_fifo;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int AFULL  = 12;
    localparam int RESUME = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    uart_rx_fifo_if #(.ADDR_W(ADDR_W)) bus_if ();

    uart_rx_fifo #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W),
        .AFULL_LEVEL(AFULL), .RESUME_LEVEL(RESUME)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus_if)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the contents as a queue, plus the rts and overflow flags.
    byte unsigned mq[$];
    bit m_ovf = 1'b0;
    bit m_rts = 1'b1;

    typedef struct {
        bit         rxv;
        logic [7:0] b;
        bit         rd;
        bit         clr;
        int         e_level;
        bit         e_valid;
        logic [7:0] e_data;
        bit         chk_data;
        bit         e_rts;
        bit         e_ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_vec++;
        if (act !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_rts = 1'b1;
    endtask

    // Apply the FIFO rules from the state seen before the clock edge.
    task automatic model_update(input bit rxv, input logic [7:0] b, input bit rd, input bit clr);
        int  sz;
        bit  do_pop;
        bit  do_push;
        sz      = mq.size();
        do_pop  = rd && (sz > 0);
        do_push = rxv && ((sz < DEPTH) || do_pop);
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(b);
        if (rxv && !do_push) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        sz = mq.size();
        if (m_rts && sz >= AFULL) m_rts = 1'b0;
        else if (!m_rts && sz <= RESUME) m_rts = 1'b1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".level"}, bus_if.level, mq.size());
        chk({tag, ".empty"}, bus_if.empty, int'(mq.size() == 0));
        chk({tag, ".full"}, bus_if.full, int'(mq.size() == DEPTH));
        chk({tag, ".rd_valid"}, bus_if.rd_valid, int'(mq.size() != 0));
        chk({tag, ".rts"}, bus_if.rts, int'(m_rts));
        chk({tag, ".overflow"}, bus_if.overflow, int'(m_ovf));
        if (mq.size() != 0) chk({tag, ".rd_data"}, bus_if.rd_data, int'(mq[0]));
    endtask

    // One clock cycle: drive the inputs, advance the model at the edge, then check 1 time unit later.
    task automatic step(input string tag, input bit rxv, input logic [7:0] b,
                        input bit rd, input bit clr);
        bus_if.rx_valid = rxv;
        bus_if.rx_byte  = b;
        bus_if.rd_en    = rd;
        bus_if.clr_ovf  = clr;
        @(posedge clk);
        model_update(rxv, b, rd, clr);
        #1;
        chk_model(tag);
    endtask

    vec_t tbl[8];

    initial begin
        logic [7:0] exp_b;
        int         rd_pct;

        bus_if.rx_valid = 1'b0;
        bus_if.rx_byte  = 8'h00;
        bus_if.rd_en    = 1'b0;
        bus_if.clr_ovf  = 1'b0;

        // Expected values in the table come straight from the basic push/pop scenario.
        //           rxv  byte   rd clr lvl vld data  chkd rts ovf
        tbl[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 1, 1'b1, 8'h41, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 8'h42, 1'b0, 1'b0, 2, 1'b1, 8'h41, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 8'h43, 1'b0, 1'b0, 3, 1'b1, 8'h41, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1, 8'h42, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 8'h43, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};

        // Reset state while reset is held low.
        @(posedge clk);
        #1;
        chk("rst.level", bus_if.level, 0);
        chk("rst.empty", bus_if.empty, 1);
        chk("rst.full", bus_if.full, 0);
        chk("rst.rd_valid", bus_if.rd_valid, 0);
        chk("rst.rts", bus_if.rts, 1);
        chk("rst.overflow", bus_if.overflow, 0);
        $display("reset: level=%0d empty=%0b rts=%0b", bus_if.level, bus_if.empty, bus_if.rts);
        reset = 1'b1;
        model_reset();

        // Directed table for the basic push/pop case.
        for (int i = 0; i < 8; i++) begin
            step("tbl", tbl[i].rxv, tbl[i].b, tbl[i].rd, tbl[i].clr);
            chk("tbl.level", bus_if.level, tbl[i].e_level);
            chk("tbl.rd_valid", bus_if.rd_valid, int'(tbl[i].e_valid));
            chk("tbl.rts", bus_if.rts, int'(tbl[i].e_rts));
            chk("tbl.overflow", bus_if.overflow, int'(tbl[i].e_ovf));
            if (tbl[i].chk_data) chk("tbl.rd_data", bus_if.rd_data, int'(tbl[i].e_data));
            $display("vec %0d: rxv=%0b byte=%02h rd=%0b -> level=%0d rd_data=%02h",
                     i, tbl[i].rxv, tbl[i].b, tbl[i].rd, bus_if.level, bus_if.rd_data);
        end

        // Twelve pushes take rts low. Popping back down to 4 raises it again.
        for (int i = 0; i < 12; i++) begin
            step("afull.push", 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
            chk("afull.rts_push", bus_if.rts, (i == 11) ? 0 : 1);
        end
        for (int i = 0; i < 8; i++) begin
            step("afull.pop", 1'b0, 8'h00, 1'b1, 1'b0);
            chk("afull.rts_pop", bus_if.rts, (i == 7) ? 1 : 0);
        end
        $display("afull: level=%0d rts=%0b after drain to resume", bus_if.level, bus_if.rts);
        for (int i = 0; i < 4; i++) step("afull.drain", 1'b0, 8'h00, 1'b1, 1'b0);

        // Fill the FIFO, then offer two more bytes; both must be dropped.
        for (int i = 0; i < DEPTH; i++) step("ovf.fill", 1'b1, 8'(8'h01 + 3 * i), 1'b0, 1'b0);
        chk("ovf.full", bus_if.full, 1);
        step("ovf.drop", 1'b1, 8'hEE, 1'b0, 1'b0);
        step("ovf.drop", 1'b1, 8'hEF, 1'b0, 1'b0);
        chk("ovf.flag", bus_if.overflow, 1);
        chk("ovf.level", bus_if.level, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            exp_b = 8'(8'h01 + 3 * i);
            chk("ovf.order", bus_if.rd_data, int'(exp_b));
            step("ovf.drain", 1'b0, 8'h00, 1'b1, 1'b0);
        end
        step("ovf.clr", 1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf.cleared", bus_if.overflow, 0);
        $display("overflow: dropped 2, drained 16, cleared ovf=%0b", bus_if.overflow);

        // On a full FIFO, a push and a pop in the same cycle both happen; 0x55 then leaves last after wrap.
        for (int i = 0; i < DEPTH; i++) step("wrap.fill", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        step("wrap.both", 1'b1, 8'h55, 1'b1, 1'b0);
        chk("wrap.level", bus_if.level, DEPTH);
        chk("wrap.ovf", bus_if.overflow, 0);
        for (int i = 0; i < DEPTH - 1; i++) step("wrap.drain", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("wrap.last", bus_if.rd_data, 8'h55);
        step("wrap.drain", 1'b0, 8'h00, 1'b1, 1'b0);
        $display("wrap: last byte 0x55 read, level=%0d", bus_if.level);

        // On an empty FIFO, a push and a pop in the same cycle: only the push happens.
        step("byp.both", 1'b1, 8'h7A, 1'b1, 1'b0);
        chk("byp.level", bus_if.level, 1);
        chk("byp.data", bus_if.rd_data, 8'h7A);
        step("byp.pop", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("byp.empty", bus_if.empty, 1);
        step("byp.idle_rd", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("byp.level2", bus_if.level, 0);
        $display("bypass: 0x7A pushed and popped, level=%0d", bus_if.level);

        // Queue 8 bytes, then pull reset low in the middle of the stream.
        for (int i = 0; i < 8; i++) step("rst.fill", 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        bus_if.rx_valid = 1'b0;
        bus_if.rd_en    = 1'b0;
        reset = 1'b0;
        #1;
        chk("arst.level", bus_if.level, 0);
        chk("arst.empty", bus_if.empty, 1);
        chk("arst.rts", bus_if.rts, 1);
        chk("arst.overflow", bus_if.overflow, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        step("arst.push", 1'b1, 8'h10, 1'b0, 1'b0);
        chk("arst.data", bus_if.rd_data, 8'h10);
        $display("async reset: cleared, then 0x10 reads back as %02h", bus_if.rd_data);

        // Random traffic. The read probability changes between phases to swing the FIFO across both thresholds.
        for (int blk = 0; blk < 15; blk++) begin
            rd_pct = (blk % 3 == 0) ? 15 : ((blk % 3 == 1) ? 85 : 50);
            for (int i = 0; i < 200; i++) begin
                step("rand", 1'($urandom_range(1, 100) <= 60), 8'($urandom),
                     1'($urandom_range(1, 100) <= rd_pct),
                     1'($urandom_range(1, 100) <= 5));
            end
            $display("rand block %0d: level=%0d rts=%0b ovf=%0b", blk, bus_if.level,
                     bus_if.rts, bus_if.overflow);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side byte buffer sitting directly downstream of the UART receiver.
- Captures each received byte on a one-cycle strobe and holds it in a circular FIFO until the host pops it.
- Drives the hardware flow-control line (rts) with hysteresis so the remote transmitter pauses before the buffer overflows.
- Flags dropped bytes with a sticky overflow bit.

Parameters:
- DEPTH, 16, number of byte entries; power of two, minimum 4.
- ADDR_W, 4, log2(DEPTH); the pointer width.
- AFULL_LEVEL, 12, occupancy at or above which rts is deasserted; range 1..DEPTH.
- RESUME_LEVEL, 4, occupancy at or below which rts is reasserted; must be less than AFULL_LEVEL.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx_valid  input  1  one-cycle strobe: rx_byte holds a newly received byte.
- rx_byte  input  8  received byte, sampled when rx_valid=1.
- rd_en  input  1  host pop request; effective only while rd_valid=1.
- clr_ovf  input  1  synchronous clear of overflow.
- rd_data  output  8  head-of-FIFO byte; valid while rd_valid=1 (first-word-fall-through).
- rd_valid  output  1  FIFO non-empty.
- level  output  ADDR_W+1  current occupancy, 0..DEPTH.
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.
- rts  output  1  high = remote may transmit (connects to the remote cts).
- overflow  output  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Reset values while reset=0, asynchronously:
  - wr_ptr=0, rd_ptr=0, level=0
  - empty=1, full=0, rd_valid=0
  - rts=1, overflow=0
  - rd_data content is don't-care; memory contents are not reset.
- Storage:
  - DEPTH x 8 register array.
  - wr_ptr and rd_ptr are ADDR_W-bit and wrap naturally from DEPTH-1 to 0.
  - level is a separate ADDR_W+1-bit counter.
- Push = rx_valid & (~full | pop).
  - Writes rx_byte to mem[wr_ptr] and increments wr_ptr.
- Pop = rd_en & rd_valid.
  - Increments rd_ptr.
  - rd_en while empty is ignored: no pointer change, no error.
- Level update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full with simultaneous push and pop: both occur; level stays DEPTH.
- Empty with simultaneous rx_valid and rd_en: the push occurs, the pop is ignored, level becomes 1.
- Read latency (FWFT):
  - rd_data = mem[rd_ptr], combinational from registered state.
  - A byte pushed in cycle N appears on rd_data with rd_valid=1 in cycle N+1.
  - After a pop, the next entry is presented in the following cycle.
- empty, full and rd_valid are decoded from the registered level; no glitches from inputs.
- Overflow:
  - rx_valid & full & ~pop: the byte is dropped; pointers and level are unchanged; overflow is set next cycle.
  - overflow stays high until a clr_ovf cycle without a new drop.
  - Set wins over clear in the same cycle.
- rts, a registered two-state FSM:
  - RUN (rts=1) goes to HOLD when the next level >= AFULL_LEVEL.
  - HOLD (rts=0) goes to RUN when the next level <= RESUME_LEVEL.
  - Otherwise the state holds.
  - rts changes one cycle after the push or pop that crosses a threshold, in the same cycle as the level update.
- Reset asserted mid-operation: all state returns to the reset values immediately; queued bytes are lost; the FSM goes to RUN.
- No combinational path from any input to any output except rd_data via pointer state (none from inputs).

Test Plan:
- Reset, then 3 pushes 0x41, 0x42, 0x43 with no reads:
  - level=3, rd_valid=1, rd_data=0x41.
  - Pops in 3 consecutive cycles return 0x41, 0x42, 0x43; then empty=1, level=0.
- 12 pushes with DEPTH=16 and AFULL_LEVEL=12:
  - rts falls the cycle after the 12th push.
  - Popping down to 5 keeps rts=0; the pop reaching level 4 raises rts the next cycle.
- Fill to 16 (full=1), then 2 further rx_valid bytes 0xEE, 0xEF:
  - Both are dropped; overflow=1, level=16.
  - Draining returns the original 16 bytes in order.
  - clr_ovf then gives overflow=0.
- Full FIFO with rx_valid=0x55 and rd_en in the same cycle:
  - level stays 16 and overflow stays 0.
  - 0x55 is read out last after 16 pops, including wrap of both pointers past index 15.
- Empty FIFO with rd_en and rx_valid=0x7A in the same cycle:
  - level=1 and rd_data=0x7A next cycle.
  - Held rd_en then pops it the following cycle; a further rd_en on empty changes nothing.
- 8 bytes queued, reset pulled low mid-stream for one cycle:
  - Outputs go immediately to level=0, empty=1, rts=1, overflow=0.
  - A subsequent push of 0x10 reads back as 0x10.
